// File: rtl/mux_nx1_scan.sv
// Registered N_CH:1 multiplexer with manual select and auto-scan modes.
// The output carries the sourced channel index, a valid flag and an end-of-sweep pulse.
module mux_nx1_scan #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH),
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      select,
    output logic [WIDTH-1:0]      y,
    output logic [SEL_W-1:0]      y_ch,
    output logic                  y_valid,
    output logic                  scan_done
);

    localparam int               DW_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_CH_X  = (SEL_W + 1)'(N_CH);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  scan_ch, scan_ch_d;
    logic [DW_W-1:0]   dwell_cnt, dwell_d;
    logic [WIDTH-1:0]  y_d;
    logic [SEL_W-1:0]  y_ch_d;
    logic              y_valid_d, scan_done_d;

    logic [SEL_W-1:0]  cur_ch;
    logic [DW_W-1:0]   cur_dwell;
    logic [SEL_W-1:0]  mux_idx;
    logic [WIDTH-1:0]  mux_data;
    logic              sel_legal;

    // Entering AUTO from MANUAL restarts the sweep, so stale scan state is ignored.
    always_comb begin
        cur_ch    = (state_q == AUTO) ? scan_ch   : '0;
        cur_dwell = (state_q == AUTO) ? dwell_cnt : '0;
        sel_legal = ({1'b0, select} < N_CH_X);
        mux_idx   = mode ? cur_ch : select;
    end

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (mux_idx == SEL_W'(i)) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        scan_ch_d   = scan_ch;
        dwell_d     = dwell_cnt;
        y_d         = y;
        y_ch_d      = y_ch;
        y_valid_d   = 1'b0;
        scan_done_d = 1'b0;

        if (en) begin
            state_d = mode ? AUTO : MANUAL;
            case (state_d)
                MANUAL: begin
                    if (sel_legal) begin
                        y_d       = mux_data;
                        y_ch_d    = select;
                        y_valid_d = 1'b1;
                    end
                end
                AUTO: begin
                    y_d       = mux_data;
                    y_ch_d    = cur_ch;
                    y_valid_d = 1'b1;
                    if (cur_dwell == LAST_DW) begin
                        dwell_d     = '0;
                        scan_ch_d   = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
                        scan_done_d = (cur_ch == LAST_CH);
                    end else begin
                        dwell_d   = cur_dwell + DW_W'(1);
                        scan_ch_d = cur_ch;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MANUAL;
            scan_ch   <= '0;
            dwell_cnt <= '0;
            y         <= '0;
            y_ch      <= '0;
            y_valid   <= 1'b0;
            scan_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            scan_ch   <= scan_ch_d;
            dwell_cnt <= dwell_d;
            y         <= y_d;
            y_ch      <= y_ch_d;
            y_valid   <= y_valid_d;
            scan_done <= scan_done_d;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed and randomised checks of mux_nx1_scan: DUT A (N_CH=3, DWELL=2), DUT B (N_CH=4, DWELL=1).
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, mode;
    logic [23:0] in_a;
    logic [31:0] in_b;
    logic [1:0]  sel_a, sel_b;
    logic [7:0]  y_a, y_b;
    logic [1:0]  ych_a, ych_b;
    logic        val_a, val_b, done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: sweep position is a flat index 0..N*D-1 per DUT.
    logic [7:0] m_y[2];
    int         m_ych[2];
    logic       m_valid[2], m_done[2], m_auto[2];
    int         m_pos[2];

    always #5 clk = ~clk;

    mux_nx1_scan #(.WIDTH(8), .N_CH(3), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_a), .en(en), .mode(mode), .select(sel_a),
        .y(y_a), .y_ch(ych_a), .y_valid(val_a), .scan_done(done_a)
    );

    mux_nx1_scan #(.WIDTH(8), .N_CH(4), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_b), .en(en), .mode(mode), .select(sel_b),
        .y(y_b), .y_ch(ych_b), .y_valid(val_b), .scan_done(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [7:0] ey, input int ech,
                           input logic ev, input logic ed);
        check({tag, ".y"},         {24'b0, y_a},    {24'b0, ey});
        check({tag, ".y_ch"},      {30'b0, ych_a},  ech);
        check({tag, ".y_valid"},   {31'b0, val_a},  {31'b0, ev});
        check({tag, ".scan_done"}, {31'b0, done_a}, {31'b0, ed});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_y[k] = '0; m_ych[k] = 0; m_valid[k] = 0; m_done[k] = 0;
            m_auto[k] = 0; m_pos[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input int n, input int d, input logic [31:0] data,
                              input int sel);
        int p;
        if (!en) begin
            m_valid[k] = 0; m_done[k] = 0;
        end else if (!mode) begin
            if (sel < n) begin
                m_y[k] = data[8*sel +: 8]; m_ych[k] = sel; m_valid[k] = 1;
            end else begin
                m_valid[k] = 0;
            end
            m_done[k] = 0; m_auto[k] = 0;
        end else begin
            p = m_auto[k] ? m_pos[k] : 0;
            m_ych[k]   = p / d;
            m_y[k]     = data[8*m_ych[k] +: 8];
            m_valid[k] = 1;
            m_done[k]  = (p == n*d - 1);
            m_pos[k]   = (p + 1) % (n*d);
            m_auto[k]  = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, 3, 2, {8'b0, in_a}, int'(sel_a));
        model_step(1, 4, 1, in_b, int'(sel_b));
        #1;
    endtask

    int exp_ch[7]   = '{0, 0, 1, 1, 2, 2, 0};
    logic exp_dn[7] = '{0, 0, 0, 0, 0, 1, 0};
    logic [7:0] chv[3] = '{8'hAA, 8'hBB, 8'hCC};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel_a = '0; sel_b = '0;
        in_a = {8'hCC, 8'hBB, 8'hAA}; in_b = 32'h44332211;
        #12;
        check_a("reset_init", 8'h00, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Manual sweep
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_a = 2'(i);
            step();
            check_a($sformatf("manual%0d", i), chv[i], i, 1, 0);
        end

        // Asynchronous reset mid-cycle with outputs nonzero
        #2 rst = 1'b1;
        #1 check_a("async_reset", 8'h00, 0, 0, 0);
        rst = 1'b0;

        // Illegal select holds y/y_ch
        sel_a = 2'd1;
        step();
        check_a("pre_illegal", 8'hBB, 1, 1, 0);
        sel_a = 2'd3;
        step();
        check_a("illegal_sel", 8'hBB, 1, 0, 0);

        // Auto sweep from manual
        mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check_a($sformatf("auto%0d", i), chv[exp_ch[i]], exp_ch[i], 1, exp_dn[i]);
        end

        // Enable pause after the first y_ch=1 cycle
        step();
        check_a("pause_pre0", 8'hAA, 0, 1, 0);
        step();
        check_a("pause_pre1", 8'hBB, 1, 1, 0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a($sformatf("paused%0d", i), 8'hBB, 1, 0, 0);
        end
        en = 1'b1;
        step();
        check_a("resume0", 8'hBB, 1, 1, 0);
        step();
        check_a("resume1", 8'hCC, 2, 1, 0);

        // Randomised run against the reference model, both DUTs
        rst = 1'b1; #2; rst = 1'b0;
        model_reset();
        for (int it = 0; it < 15; it++) begin
            for (int c = 0; c < 20; c++) begin
                in_a  = 24'($urandom);
                in_b  = $urandom;
                sel_a = 2'($urandom_range(0, 3));
                sel_b = 2'($urandom_range(0, 3));
                en    = ($urandom_range(0, 9) < 8);
                if ($urandom_range(0, 7) == 0) mode = ~mode;
                step();
                check("rnd.A.y",         {24'b0, y_a},    {24'b0, m_y[0]});
                check("rnd.A.y_ch",      {30'b0, ych_a},  m_ych[0]);
                check("rnd.A.y_valid",   {31'b0, val_a},  {31'b0, m_valid[0]});
                check("rnd.A.scan_done", {31'b0, done_a}, {31'b0, m_done[0]});
                check("rnd.B.y",         {24'b0, y_b},    {24'b0, m_y[1]});
                check("rnd.B.y_ch",      {30'b0, ych_b},  m_ych[1]);
                check("rnd.B.y_valid",   {31'b0, val_b},  {31'b0, m_valid[1]});
                check("rnd.B.scan_done", {31'b0, done_b}, {31'b0, m_done[1]});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised, registered N-channel to 1 multiplexer; generalises the 2:1 combinational mux to N_CH channels of WIDTH bits.
- Two modes: manual (external select) and auto-scan (internal channel counter, fixed dwell per channel).
- Sits between parallel data sources and a single-lane consumer (display/serial path).
- Output carries the sourced channel index and a valid flag.

Parameters:
- WIDTH, 8, bits per channel.
- N_CH, 4, number of input channels (>=2; need not be a power of 2).
- SEL_W, $clog2(N_CH), width of select and channel index.
- DWELL, 4, enabled cycles spent on each channel in auto mode (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_data  in  N_CH*WIDTH  channel i = in_data[i*WIDTH +: WIDTH].
- en  in  1  cycle enable; low freezes all state.
- mode  in  1  0 = manual, 1 = auto-scan.
- select  in  SEL_W  channel index in manual mode; ignored in auto mode.
- y  out  WIDTH  registered selected data.
- y_ch  out  SEL_W  index of the channel currently driving y.
- y_valid  out  1  y/y_ch updated this cycle from a legal channel.
- scan_done  out  1  one-cycle pulse at the end of a full auto sweep.

Behaviour:
- Reset (async, while rst=1): y=0, y_ch=0, y_valid=0, scan_done=0, scan_ch=0, dwell_cnt=0, mode_q=0.
- All outputs registered; latency 1 clk from in_data/select/mode sample to y.
- en=0: y, y_ch hold; y_valid<=0; scan_done<=0; scan_ch, dwell_cnt, mode_q frozen.
- FSM has two states, MANUAL and AUTO, with state = mode sampled on each enabled edge; mode_q is the registered previous mode.
- MANUAL (en=1, mode=0):
  - select<N_CH: y<=ch[select], y_ch<=select, y_valid<=1.
  - select>=N_CH (illegal, only possible when N_CH is not a power of 2): y, y_ch hold; y_valid<=0.
  - scan_ch and dwell_cnt hold; scan_done<=0.
- AUTO entry (en=1, mode=1, mode_q=0):
  - Treated as scan_ch=0, dwell_cnt=0 for this cycle.
  - y<=ch[0], y_ch<=0, y_valid<=1.
  - dwell_cnt<=1, or advance immediately if DWELL=1.
- AUTO steady (en=1, mode=1, mode_q=1):
  - y<=ch[scan_ch], y_ch<=scan_ch, y_valid<=1.
  - dwell_cnt<DWELL-1: dwell_cnt<=dwell_cnt+1.
  - dwell_cnt==DWELL-1: dwell_cnt<=0; scan_ch<=(scan_ch==N_CH-1)?0:scan_ch+1.
  - scan_done<=1 exactly on the cycle that presents the final dwell cycle of channel N_CH-1 (the wrap); 0 otherwise.
- AUTO to MANUAL: the next enabled cycle follows MANUAL rules immediately; the scan state is discarded because re-entry restarts at channel 0.
- en low during AUTO: dwell is paused, not reset; it resumes where it stopped when en returns.
- Reset mid-scan: immediate return to reset values; the first enabled cycle after release with mode=1 counts as AUTO entry (mode_q=0).
- in_data is not registered; changes to a channel during dwell appear on y the next cycle.

Test Plan (WIDTH=8, N_CH=3, DWELL=2 unless stated):
- Reset: assert rst asynchronously mid-cycle with outputs nonzero. Required: y=0x00, y_ch=0, y_valid=0, scan_done=0 before the next clk edge.
- Manual sweep: in_data={0xCC,0xBB,0xAA}, mode=0, select=0,1,2 on consecutive cycles. Required: y=0xAA,0xBB,0xCC one cycle later; y_ch=0,1,2; y_valid=1.
- Illegal select: mode=0, select=3 after select=1 (y=0xBB). Required: y=0xBB and y_ch=1 hold; y_valid=0.
- Auto sweep: mode=1 from manual, en=1 for 7 cycles. Required: y_ch sequence 0,0,1,1,2,2,0; scan_done=1 only on the second cycle with y_ch=2.
- Enable pause: auto mode, drop en for 3 cycles after the first y_ch=1 cycle. Required: y_valid=0 and y holds during the pause; after en returns, one more y_ch=1 cycle, then y_ch=2.
- Randomised run (15 iterations, mirroring the 2:1 bench): random in_data, mode, select, en. A reference model checks y, y_ch, y_valid and scan_done every cycle; re-run with N_CH=4, DWELL=1 to cover wrap every cycle.
